// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Default width of the stall/flush event counters.
    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one when inc_i is high, holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid buffer, flush and event counters.
// Build option: define PIPE_STAGE_SKID_EN to add the skid register and make
// in_ready a pure function of registered state; otherwise in_ready depends
// combinationally on out_ready and the stage holds at most one entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 64,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic             stall_inc;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    // Accept whenever the skid slot is free; no path from out_ready.
    assign in_ready = (state_q != TWO);
`else
    // Accept when empty or when the held entry leaves this cycle.
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign stall_inc = out_valid_q && !out_ready && !flush;

    // Occupancy FSM with main/skid storage; flush overrides every transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= NOP_VALUE;
`endif
        end else if (flush) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q      <= NOP_VALUE;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        main_q      <= NOP_VALUE;
                        out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        state_q <= TWO;
                        skid_q  <= in_data;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    if (out_fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= NOP_VALUE;
                    end
                end
`endif
                default: begin
                    state_q     <= EMPTY;
                    main_q      <= NOP_VALUE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush),
        .cnt_o (flush_cnt)
    );

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (e.g. pc_inc and instruction concatenated).
REQ-002 Parameter NOP_VALUE, default 0 (WIDTH bits), payload presented when the stage holds a bubble.
REQ-003 Parameter CNT_W, default 16, width of each event counter.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  stage can accept in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 flush  input  1  squash all held entries (branch/exception bubble).
REQ-010 out_valid  output  1  out_data is a real instruction.
REQ-011 out_ready  input  1  downstream accepts out_data; low means stall.
REQ-012 out_data  output  WIDTH  head payload, or NOP_VALUE when out_valid=0.
REQ-013 stall_cnt  output  CNT_W  saturating count of stall cycles.
REQ-014 flush_cnt  output  CNT_W  saturating count of flush cycles.

Function
REQ-015 Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready at rising edge.
REQ-016 Storage is a main register plus one skid register; FSM states EMPTY, ONE (main valid), TWO (main+skid valid).
REQ-017 EMPTY: in-transfer -> ONE; otherwise stay.
REQ-018 ONE: in+out -> ONE (main <= in_data); in only -> TWO (skid <= in_data); out only -> EMPTY; neither -> ONE.
REQ-019 TWO: out-transfer -> ONE (main <= skid); otherwise stay; no in-transfer possible (in_ready=0).
REQ-020 Latency: one cycle from in-transfer to out_valid when stage was EMPTY or ONE-with-out-transfer; full throughput (one transfer per cycle) while out_ready=1.
REQ-021 out_valid=1 in ONE and TWO; out_data = main register in those states, NOP_VALUE in EMPTY.
REQ-022 Data order strictly FIFO; no entry dropped or duplicated except by flush.
REQ-023 flush=1 wins over every other event: next state EMPTY, main and skid set to NOP_VALUE, any simultaneous in/out transfer discarded and not counted as delivered.
REQ-024 Stall cycle = out_valid && !out_ready && !flush; stall_cnt increments by 1, saturates at all-ones.
REQ-025 flush_cnt increments by 1 on each cycle with flush=1, saturates at all-ones.
REQ-026 Counters never wrap; both clear only on Rst.

Reset
REQ-027 Rst high asynchronously forces state EMPTY, main/skid = NOP_VALUE, out_valid=0, out_data=NOP_VALUE, stall_cnt=0, flush_cnt=0.
REQ-028 in_ready during Rst follows the EMPTY value for the configured mode (1); no transfer is recorded while Rst is high.
REQ-029 Rst mid-operation discards all held entries; first edge after deassertion behaves as from EMPTY.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: skid register present, in_ready = (state != TWO), a registered-state function with no combinational path from out_ready.
REQ-031 PIPE_STAGE_SKID_EN undefined: no skid register, state TWO unreachable, in_ready = !out_valid || out_ready (combinational), all other requirements unchanged.

Structure
REQ-032 Shared package pipe_pkg holds the FSM state enum (EMPTY, ONE, TWO) and the default counter width constant.
REQ-033 One sub-module sat_counter (parametrised width, inc, saturating) instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-034 Pass-through: out_ready=1, send 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles one cycle later, stall_cnt=0.
REQ-035 Backpressure (SKID_EN): ONE holding 0xA, out_ready=0, push 0xB -> state TWO, in_ready=0, stall_cnt increments each cycle; release -> 0xA then 0xB.
REQ-036 Flush with simultaneous push in TWO -> next cycle out_valid=0, out_data=NOP_VALUE, pushed word never appears, flush_cnt=1.
REQ-037 Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt stops at 15.
REQ-038 Async reset asserted mid-cycle while in TWO -> outputs reach reset values before next edge; after release 0x55 in -> 0x55 out one cycle later.
REQ-039 Without PIPE_STAGE_SKID_EN: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
